// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------------------------------------------------------------------
// Generic pipeline-stage register with a valid/ready handshake. A main entry
// register plus a one-deep skid register let the stage keep accepting while
// downstream stalls for one cycle, without any combinational path from
// out_ready back to in_ready. The stage also provides a synchronous flush
// that turns the stage into a bubble, and a saturating counter of stalled
// cycles. Control bits are masked to zero whenever the stage holds a bubble,
// so a killed instruction can never assert RegWrite/MemWrite downstream.
//
// Ports
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high reset
//   flush      in   1       synchronous kill of all held entries
//   in_valid   in   1       upstream entry valid
//   in_ready   out  1       stage can accept (from state flops only)
//   in_data    in   DATA_W  upstream payload
//   in_ctrl    in   CTRL_W  upstream control bits
//   out_valid  out  1       head entry valid
//   out_ready  in   1       downstream accepts head entry
//   out_data   out  DATA_W  head payload
//   out_ctrl   out  CTRL_W  head control bits, zero when out_valid=0
//   stall_cnt  out  STAT_W  cycles with out_valid & !out_ready, saturating
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [STAT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
  logic [STAT_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic acc;
  logic drn;

  // Handshake flags are decoded purely from the state register.
  assign out_valid = (state_reg != EMPTY);
  assign in_ready  = (state_reg != TWO);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  assign out_data  = main_data_reg;
  assign out_ctrl  = out_valid ? main_ctrl_reg : '0;
  assign stall_cnt = stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      main_ctrl_reg <= main_ctrl_next;
      skid_data_reg <= skid_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    main_ctrl_next = main_ctrl_reg;
    skid_data_next = skid_data_reg;
    skid_ctrl_next = skid_ctrl_reg;

    if (flush) begin
      // Flush wins over everything: the incoming entry is dropped and the
      // payload registers keep their stale contents (masked by out_ctrl).
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (acc) begin
            state_next     = ONE;
            main_data_next = in_data;
            main_ctrl_next = in_ctrl;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_data_next = in_data;
            main_ctrl_next = in_ctrl;
          end else if (acc) begin
            // Downstream stalled: park the new entry behind the head.
            state_next     = TWO;
            skid_data_next = in_data;
            skid_ctrl_next = in_ctrl;
          end else if (drn) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain needs handling.
          if (drn) begin
            state_next     = ONE;
            main_data_next = skid_data_reg;
            main_ctrl_next = skid_ctrl_reg;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // Counts stalled cycles including a flush cycle; flush never clears it.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (out_valid && !out_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_next = stall_cnt_reg + STAT_W'(1);
    end
  end

endmodule
